// File: rtl/period_readout_pkg.sv
// Shared sizing constants and the input-state type for the period readout receive path.
package period_readout_pkg;

    localparam int COUNTER_BITS    = 16;
    localparam int PIXELS_PER_LANE = 8;
    localparam int FRAME_BITS      = COUNTER_BITS * PIXELS_PER_LANE;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } input_state_t;

endpackage

// File: rtl/frame_deserializer.sv
// Collects one MSB-first serial frame behind a FRAME_SYNC marker.
// frame_valid/frame are combinational on the cycle the last bit is on serial_in.
module frame_deserializer
    import period_readout_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             frame_sync,
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame,
    output logic             sync_error
);

    localparam int CNT_BITS = $clog2(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(WIDTH - 1);

    input_state_t        state_q;
    input_state_t        state_d;
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic [WIDTH-1:0]    shift_q;
    logic [WIDTH-1:0]    shift_next;
    logic                shift_en;
    logic                sync_error_d;

    assign shift_next = {shift_q[WIDTH-2:0], serial_in};
    assign frame      = shift_next;

    // A sync seen while already shifting restarts the frame on that same bit.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_en     = 1'b0;
        frame_valid  = 1'b0;
        sync_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_sync) begin
                    shift_en = 1'b1;
                    count_d  = CNT_BITS'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (frame_sync) begin
                    sync_error_d = 1'b1;
                    count_d      = CNT_BITS'(1);
                end else if (count_q == LAST_COUNT) begin
                    frame_valid = 1'b1;
                    count_d     = '0;
                    state_d     = IDLE;
                end else begin
                    count_d = count_q + CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            sync_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sync_error <= sync_error_d;
            if (shift_en) begin
                shift_q <= shift_next;
            end
        end
    end

endmodule

// File: rtl/period_stream_receiver.sv
// One lane of the serial period-readout stream: deserialise a frame, hold it,
// and hand the words out one per VALID/READY transfer with their pixel index.
module period_stream_receiver #(
    parameter int  COUNTER_BITS    = period_readout_pkg::COUNTER_BITS,
    parameter int  PIXELS_PER_LANE = period_readout_pkg::PIXELS_PER_LANE,
    localparam int FRAME_BITS      = COUNTER_BITS * PIXELS_PER_LANE,
    localparam int INDEX_BITS      = $clog2(PIXELS_PER_LANE)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SERIAL_IN,
    input  logic                    FRAME_SYNC,
    output logic [COUNTER_BITS-1:0] PIXEL_DATA,
    output logic [INDEX_BITS-1:0]   PIXEL_INDEX,
    output logic                    PIXEL_VALID,
    input  logic                    PIXEL_READY,
    output logic                    FRAME_DONE,
    output logic                    OVERRUN,
    output logic                    SYNC_ERROR
);

    import period_readout_pkg::*;

    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(PIXELS_PER_LANE - 1);

    logic                  frame_valid;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] holding_q;
    logic                  valid_q;
    logic [INDEX_BITS-1:0] index_q;
    logic                  overrun_q;
    logic                  accept;
    logic                  last_accept;
    logic                  can_load;

    frame_deserializer #(
        .WIDTH (FRAME_BITS)
    ) u_deserializer (
        .clk         (CLK),
        .rst         (RST),
        .serial_in   (SERIAL_IN),
        .frame_sync  (FRAME_SYNC),
        .frame_valid (frame_valid),
        .frame       (frame),
        .sync_error  (SYNC_ERROR)
    );

    assign accept      = valid_q && PIXEL_READY;
    assign last_accept = accept && (index_q == LAST_INDEX);
    // Releasing the last word frees the holding register for a frame finishing in the same cycle.
    assign can_load    = !valid_q || last_accept;

    always_ff @(posedge CLK) begin
        if (RST) begin
            holding_q <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            overrun_q <= 1'b0;
        end else if (frame_valid && can_load) begin
            holding_q <= frame;
            valid_q   <= 1'b1;
            index_q   <= '0;
        end else begin
            if (frame_valid) begin
                overrun_q <= 1'b1;
            end
            if (last_accept) begin
                valid_q <= 1'b0;
                index_q <= '0;
            end else if (accept) begin
                index_q <= index_q + INDEX_BITS'(1);
            end
        end
    end

    assign PIXEL_DATA  = holding_q[index_q*COUNTER_BITS +: COUNTER_BITS];
    assign PIXEL_INDEX = index_q;
    assign PIXEL_VALID = valid_q;
    assign FRAME_DONE  = last_accept;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_period_stream_receiver.sv
// Directed bench for period_stream_receiver: table-driven backpressure plus frame-level sequences.
module tb_period_stream_receiver;

    localparam int CB = 16;
    localparam int NP = 8;
    localparam int FB = CB * NP;

    logic          CLK = 1'b0;
    logic          RST;
    logic          SERIAL_IN;
    logic          FRAME_SYNC;
    logic [CB-1:0] PIXEL_DATA;
    logic [2:0]    PIXEL_INDEX;
    logic          PIXEL_VALID;
    logic          PIXEL_READY;
    logic          FRAME_DONE;
    logic          OVERRUN;
    logic          SYNC_ERROR;

    period_stream_receiver dut (
        .CLK         (CLK),
        .RST         (RST),
        .SERIAL_IN   (SERIAL_IN),
        .FRAME_SYNC  (FRAME_SYNC),
        .PIXEL_DATA  (PIXEL_DATA),
        .PIXEL_INDEX (PIXEL_INDEX),
        .PIXEL_VALID (PIXEL_VALID),
        .PIXEL_READY (PIXEL_READY),
        .FRAME_DONE  (FRAME_DONE),
        .OVERRUN     (OVERRUN),
        .SYNC_ERROR  (SYNC_ERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } rec_t;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        int          exp_index;
        logic [15:0] exp_data;
        logic        exp_done;
    } vec_t;

    rec_t got_q[$];
    vec_t vecs[17];
    int   cycle_no;
    int   done_count;
    int   sync_count;
    int   checks;
    int   failures;

    // Records every accepted word away from the active edge.
    initial begin
        rec_t r;
        cycle_no   = 0;
        done_count = 0;
        sync_count = 0;
        forever begin
            @(negedge CLK);
            cycle_no++;
            if (RST === 1'b0) begin
                if (PIXEL_VALID && PIXEL_READY) begin
                    r.idx  = int'(PIXEL_INDEX);
                    r.data = PIXEL_DATA;
                    r.done = FRAME_DONE;
                    r.cyc  = cycle_no;
                    got_q.push_back(r);
                end
                if (FRAME_DONE) done_count++;
                if (SYNC_ERROR) sync_count++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic sync, input logic bit_in, input logic ready);
        FRAME_SYNC  = sync;
        SERIAL_IN   = bit_in;
        PIXEL_READY = ready;
        next_cycle();
    endtask

    function automatic logic [FB-1:0] make_frame(input logic [15:0] base, input logic [15:0] stp);
        logic [FB-1:0] f;
        f = '0;
        for (int i = 0; i < NP; i++) begin
            f[i*CB +: CB] = base + 16'(i) * stp;
        end
        return f;
    endfunction

    task automatic send_frame(input logic [FB-1:0] frame, input int ready_from);
        for (int b = 0; b < FB; b++) begin
            apply_stimulus(b == 0, frame[FB-1-b], b >= ready_from);
        end
        FRAME_SYNC = 1'b0;
        SERIAL_IN  = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            next_cycle();
            k++;
        end
        check_output({name, " words before timeout"}, got_q.size(), n);
    endtask

    task automatic check_frame(input int first, input logic [15:0] base, input logic [15:0] stp, input string name);
        for (int i = 0; i < NP; i++) begin
            if (first + i < got_q.size()) begin
                check_output($sformatf("%s idx[%0d]", name, i), got_q[first+i].idx, i);
                check_output($sformatf("%s data[%0d]", name, i), got_q[first+i].data, base + 16'(i) * stp);
                check_output($sformatf("%s done[%0d]", name, i), got_q[first+i].done, (i == NP - 1));
            end else begin
                check_output($sformatf("%s missing word %0d", name, i), got_q.size(), first + i + 1);
            end
        end
    endtask

    task automatic check_consecutive(input int n, input string name);
        for (int k = 1; k < n && k < got_q.size(); k++) begin
            check_output($sformatf("%s cycle gap %0d", name, k), got_q[k].cyc - got_q[k-1].cyc, 1);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, " valid"}, PIXEL_VALID, 0);
        check_output({name, " index"}, PIXEL_INDEX, 0);
        check_output({name, " data"}, PIXEL_DATA, 0);
        check_output({name, " done"}, FRAME_DONE, 0);
        check_output({name, " overrun"}, OVERRUN, 0);
        check_output({name, " sync_error"}, SYNC_ERROR, 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        RST         = 1'b1;
        FRAME_SYNC  = 1'b0;
        SERIAL_IN   = 1'b0;
        PIXEL_READY = 1'b0;

        // READY pattern 1,0,0,1 against a full holding register of C000+i.
        vecs[0]  = '{1'b1, 1'b1, 0, 16'hC000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1, 16'hC001, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1, 16'hC001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1, 16'hC001, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2, 16'hC002, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3, 16'hC003, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3, 16'hC003, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3, 16'hC003, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4, 16'hC004, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5, 16'hC005, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 5, 16'hC005, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 5, 16'hC005, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 6, 16'hC006, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 7, 16'hC007, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 7, 16'hC007, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 7, 16'hC007, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 0, 16'hC000, 1'b0};

        next_cycle();
        next_cycle();
        check_all_zero("reset");
        RST = 1'b0;
        next_cycle();

        $display("[TB] basic frame");
        got_q.delete();
        done_count = 0;
        send_frame(make_frame(16'hA000, 16'h0001), 0);
        check_output("basic valid latency", PIXEL_VALID, 1);
        check_output("basic first index", PIXEL_INDEX, 0);
        check_output("basic first data", PIXEL_DATA, 16'hA000);
        wait_words(8, 20, "basic");
        repeat (3) next_cycle();
        check_output("basic word count", got_q.size(), 8);
        check_frame(0, 16'hA000, 16'h0001, "basic");
        check_consecutive(8, "basic");
        check_output("basic done count", done_count, 1);
        check_output("basic valid after drain", PIXEL_VALID, 0);

        $display("[TB] backpressure");
        got_q.delete();
        done_count = 0;
        send_frame(make_frame(16'hC000, 16'h0001), FB);
        for (int i = 0; i < 17; i++) begin
            PIXEL_READY = vecs[i].ready;
            #1;
            check_output($sformatf("bp valid[%0d]", i), PIXEL_VALID, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check_output($sformatf("bp index[%0d]", i), PIXEL_INDEX, vecs[i].exp_index);
                check_output($sformatf("bp data[%0d]", i), PIXEL_DATA, vecs[i].exp_data);
            end
            check_output($sformatf("bp done[%0d]", i), FRAME_DONE, vecs[i].exp_done);
            next_cycle();
        end
        PIXEL_READY = 1'b0;
        next_cycle();
        check_output("bp word count", got_q.size(), 8);
        check_output("bp done count", done_count, 1);

        $display("[TB] back-to-back frames");
        got_q.delete();
        done_count = 0;
        send_frame(make_frame(16'h0000, 16'h1111), FB);
        send_frame(make_frame(16'h2222, 16'h0001), FB - 8);
        check_output("b2b valid at boundary", PIXEL_VALID, 1);
        check_output("b2b index at boundary", PIXEL_INDEX, 0);
        check_output("b2b data at boundary", PIXEL_DATA, 16'h2222);
        check_output("b2b overrun at boundary", OVERRUN, 0);
        PIXEL_READY = 1'b1;
        wait_words(16, 40, "b2b");
        repeat (3) next_cycle();
        check_output("b2b word count", got_q.size(), 16);
        check_frame(0, 16'h0000, 16'h1111, "b2b frame1");
        check_frame(8, 16'h2222, 16'h0001, "b2b frame2");
        check_consecutive(16, "b2b");
        check_output("b2b done count", done_count, 2);
        check_output("b2b overrun", OVERRUN, 0);

        $display("[TB] resync");
        got_q.delete();
        done_count = 0;
        sync_count = 0;
        for (int b = 0; b < 50; b++) begin
            apply_stimulus(b == 0, (b % 3) == 0, 1'b1);
        end
        send_frame(make_frame(16'hBEEF, 16'h0000), 0);
        check_output("resync valid", PIXEL_VALID, 1);
        check_output("resync first data", PIXEL_DATA, 16'hBEEF);
        wait_words(8, 20, "resync");
        repeat (3) next_cycle();
        check_output("resync word count", got_q.size(), 8);
        check_frame(0, 16'hBEEF, 16'h0000, "resync");
        check_output("resync sync_error pulses", sync_count, 1);
        check_output("resync done count", done_count, 1);

        $display("[TB] overrun");
        got_q.delete();
        done_count = 0;
        send_frame(make_frame(16'h3000, 16'h0001), FB);
        check_output("overrun clear after frame1", OVERRUN, 0);
        send_frame(make_frame(16'h4000, 16'h0001), FB);
        check_output("overrun set after frame2", OVERRUN, 1);
        check_output("overrun held index", PIXEL_INDEX, 0);
        check_output("overrun held data", PIXEL_DATA, 16'h3000);
        PIXEL_READY = 1'b1;
        wait_words(8, 20, "overrun");
        repeat (10) next_cycle();
        check_output("overrun word count", got_q.size(), 8);
        check_frame(0, 16'h3000, 16'h0001, "overrun");
        check_output("overrun sticky", OVERRUN, 1);
        check_output("overrun valid after drain", PIXEL_VALID, 0);
        check_output("overrun done count", done_count, 1);

        $display("[TB] reset mid-drain");
        got_q.delete();
        done_count = 0;
        send_frame(make_frame(16'h5000, 16'h0001), FB);
        PIXEL_READY = 1'b1;
        repeat (3) next_cycle();
        check_output("rst pre index", PIXEL_INDEX, 3);
        check_output("rst pre valid", PIXEL_VALID, 1);
        PIXEL_READY = 1'b0;
        RST = 1'b1;
        next_cycle();
        check_all_zero("rst mid-drain");
        RST = 1'b0;
        PIXEL_READY = 1'b1;
        repeat (3) next_cycle();
        check_output("rst words before reset", got_q.size(), 3);
        check_output("rst no frame_done", done_count, 0);
        got_q.delete();
        send_frame(make_frame(16'h6000, 16'h0001), 0);
        wait_words(8, 20, "post-reset");
        repeat (3) next_cycle();
        check_frame(0, 16'h6000, 16'h0001, "post-reset");
        check_output("post-reset done count", done_count, 1);
        check_output("post-reset overrun", OVERRUN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
